alu_rr_scheduler: RTL and testbench



---
 rtl/alu_ctrl_pkg.sv | 24 ++
 rtl/alu.sv | 20 ++
 rtl/alu_rr_scheduler_arb.sv | 17 +
 rtl/alu_rr_scheduler.sv | 116 +++++++++++
 tb/tb_alu_rr_scheduler.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared constants and types for the ALU round-robin scheduler:
// opcodes, FSM state encoding, latched request layout and counter width default.
package alu_ctrl_pkg;

  localparam int CNT_W_DEF = 8;

  localparam logic [1:0] OP_NOT  = 2'b00;
  localparam logic [1:0] OP_NAND = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_MUL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

  typedef struct packed {
    logic [1:0] op;
    logic [1:0] a;
    logic [1:0] b;
  } alu_req_t;

endpackage

// File: rtl/alu.sv
// Team 2-bit ALU: NOT, NAND, ADD, MUL with a 4-bit zero-extended result.
module alu (
  input  logic [1:0] A,
  input  logic [1:0] B,
  input  logic [1:0] sel,
  output logic [3:0] y
);

  always_comb begin
    y = 4'b0000;
    case (sel)
      2'b00: y = {2'b00, ~A};
      2'b01: y = {2'b00, ~(A & B)};
      2'b10: y = {2'b00, A} + {2'b00, B};
      2'b11: y = {2'b00, A} * {2'b00, B};
      default: y = 4'b0000;
    endcase
  end

endmodule

// File: rtl/alu_rr_scheduler_arb.sv
// Combinational 2-way round-robin picker; on a tie the requester that was
// not served last wins. Grant is one-hot, or zero when nobody is valid.
module rr_arb2 (
  input  logic [1:0] i_valid,
  input  logic       i_last_served,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    if (i_valid == 2'b11)
      o_grant = i_last_served ? 2'b01 : 2'b10;
    else
      o_grant = i_valid;
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one ALU between two requesters: round-robin accept in IDLE, compute
// in EXEC, hold a tagged response in RESP until the consumer takes it.
module alu_rr_scheduler
  import alu_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [1:0]       req0_a,
  input  logic [1:0]       req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [1:0]       req1_a,
  input  logic [1:0]       req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [3:0]       rsp_y,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           r_state, w_state_nxt;
  alu_req_t         r_req;
  logic             r_id;
  logic             r_last;
  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic [3:0]       r_rsp_y;
  logic [CNT_W-1:0] r_cnt0, r_cnt1;

  logic [1:0]       w_grant;
  logic             w_req_hs;
  logic             w_rsp_hs;
  logic [3:0]       w_alu_y;

  rr_arb2 u_arb (
    .i_valid       ({req1_valid, req0_valid}),
    .i_last_served (r_last),
    .o_grant       (w_grant)
  );

  alu u_alu (
    .A   (r_req.a),
    .B   (r_req.b),
    .sel (r_req.op),
    .y   (w_alu_y)
  );

  assign req0_ready = (r_state == IDLE) && w_grant[0];
  assign req1_ready = (r_state == IDLE) && w_grant[1];
  assign w_req_hs   = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign w_rsp_hs   = r_rsp_valid && rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_req_hs) w_state_nxt = EXEC;
      EXEC:    w_state_nxt = RESP;
      RESP:    if (w_rsp_hs) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // last_served resets to 1 so requester 0 takes the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req       <= '0;
      r_id        <= 1'b0;
      r_last      <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_y     <= 4'b0000;
      r_cnt0      <= '0;
      r_cnt1      <= '0;
    end else begin
      if (r_state == IDLE && w_req_hs) begin
        r_req <= w_grant[1] ? alu_req_t'{op: req1_op, a: req1_a, b: req1_b}
                            : alu_req_t'{op: req0_op, a: req0_a, b: req0_b};
        r_id  <= w_grant[1];
      end
      if (r_state == EXEC) begin
        r_rsp_y     <= w_alu_y;
        r_rsp_id    <= r_id;
        r_rsp_valid <= 1'b1;
        r_last      <= r_id;
        if (r_id) begin
          if (r_cnt1 != CNT_MAX) r_cnt1 <= r_cnt1 + CNT_W'(1);
        end else begin
          if (r_cnt0 != CNT_MAX) r_cnt0 <= r_cnt0 + CNT_W'(1);
        end
      end
      if (r_state == RESP && w_rsp_hs)
        r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_y      = r_rsp_y;
  assign grant_cnt0 = r_cnt0;
  assign grant_cnt1 = r_cnt1;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed bench for alu_rr_scheduler: scoreboard of expected responses,
// checked with immediate assertions; second instance with CNT_W=2 for saturation.
module tb_alu_rr_scheduler;

  typedef struct packed {
    logic       id;
    logic [3:0] y;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [1:0] req0_op, req0_a, req0_b, req1_op, req1_a, req1_b;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [3:0] rsp_y;
  logic [7:0] grant_cnt0, grant_cnt1;

  logic       s_v, s_rdy, s_z, s_z_rdy, s_rsp_valid, s_rsp_ready, s_rsp_id;
  logic [1:0] s_op, s_a, s_b, s_zop, s_za, s_zb;
  logic [3:0] s_rsp_y;
  logic [1:0] s_cnt0, s_cnt1;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alu_rr_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );

  alu_rr_scheduler #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(s_v), .req0_ready(s_rdy), .req0_op(s_op), .req0_a(s_a), .req0_b(s_b),
    .req1_valid(s_z), .req1_ready(s_z_rdy), .req1_op(s_zop), .req1_a(s_za), .req1_b(s_zb),
    .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_id(s_rsp_id), .rsp_y(s_rsp_y),
    .grant_cnt0(s_cnt0), .grant_cnt1(s_cnt1)
  );

  function automatic logic [3:0] model(input logic [1:0] op, input logic [1:0] a,
                                       input logic [1:0] b);
    int r;
    case (op)
      2'b00: r = (~a) & 3;
      2'b01: r = (~(a & b)) & 3;
      2'b10: r = int'(a) + int'(b);
      default: r = int'(a) * int'(b);
    endcase
    return 4'(r);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20; i++) begin
      if (req0_ready || req1_ready) break;
      tick();
    end
    chk("ready_timeout", {31'd0, req0_ready | req1_ready}, 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 0; req1_valid = 0;
    #1;
    sb.delete();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic check_rsp(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_id"}, {31'd0, rsp_id}, {31'd0, e.id});
      chk({tag, "_y"},  {28'd0, rsp_y},  {28'd0, e.y});
    end
  endtask

  // One operation on requester r with rsp_ready=1; checks the exact latency.
  task automatic run_op(input logic r, input logic [1:0] op, input logic [1:0] a,
                        input logic [1:0] b, input string tag);
    if (r) begin req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; end
    else   begin req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; end
    #1;
    wait_ready();
    chk({tag, "_ready"}, {30'd0, req1_ready, req0_ready}, r ? 32'd2 : 32'd1);
    sb.push_back('{id: r, y: model(op, a, b)});
    tick();
    req0_valid = 0; req1_valid = 0;
    chk({tag, "_exec_valid"}, {31'd0, rsp_valid}, 32'd0);
    tick();
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
    check_rsp(tag);
    tick();
    chk({tag, "_rsp_drop"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  logic [1:0] sw_op [4] = '{2'b11, 2'b00, 2'b01, 2'b10};
  logic [1:0] sw_a  [4] = '{2'd3, 2'd1, 2'd3, 2'd2};
  logic [1:0] sw_b  [4] = '{2'd2, 2'd0, 2'd1, 2'd1};
  logic [3:0] sw_y  [4] = '{4'b0110, 4'b0010, 4'b0010, 4'b0011};

  initial begin
    rst_n = 0; rsp_ready = 1;
    req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
    req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
    s_v = 0; s_op = 2'b10; s_a = 2'd1; s_b = 2'd1;
    s_z = 0; s_zop = 0; s_za = 0; s_zb = 0; s_rsp_ready = 1;
    #12;
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_id",    {31'd0, rsp_id}, 32'd0);
    chk("rst_rsp_y",     {28'd0, rsp_y}, 32'd0);
    chk("rst_cnt",       {16'd0, grant_cnt0, grant_cnt1}, 32'd0);
    tick();
    rst_n = 1;
    tick();

    // Single request on req0
    run_op(1'b0, 2'b10, 2'd3, 2'd3, "single");
    chk("single_cnt0", {24'd0, grant_cnt0}, 32'd1);

    // Opcode sweep on req1; the table values double-check the model
    for (int i = 0; i < 4; i++) begin
      chk("sweep_model", {28'd0, model(sw_op[i], sw_a[i], sw_b[i])}, {28'd0, sw_y[i]});
      run_op(1'b1, sw_op[i], sw_a[i], sw_b[i], "sweep");
    end
    chk("sweep_cnt1", {24'd0, grant_cnt1}, 32'd4);

    // Contention: both valid continuously
    do_reset();
    req0_op = 2'b11; req0_a = 2'd3; req0_b = 2'd3;
    req1_op = 2'b10; req1_a = 2'd1; req1_b = 2'd2;
    req0_valid = 1; req1_valid = 1;
    for (int k = 0; k < 4; k++) begin
      logic who;
      who = (k % 2 == 1);
      #1;
      wait_ready();
      chk("cont_ready", {30'd0, req1_ready, req0_ready}, who ? 32'd2 : 32'd1);
      sb.push_back('{id: who, y: who ? model(2'b10, 2'd1, 2'd2) : model(2'b11, 2'd3, 2'd3)});
      tick();
      tick();
      chk("cont_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check_rsp("cont");
      tick();
    end
    req0_valid = 0; req1_valid = 0;
    chk("cont_cnt0", {24'd0, grant_cnt0}, 32'd2);
    chk("cont_cnt1", {24'd0, grant_cnt1}, 32'd2);

    // Backpressure in RESP
    do_reset();
    rsp_ready = 0;
    req0_valid = 1; req0_op = 2'b01; req0_a = 2'd2; req0_b = 2'd3;
    #1;
    wait_ready();
    sb.push_back('{id: 1'b0, y: model(2'b01, 2'd2, 2'd3)});
    tick();
    req1_valid = 1;
    tick();
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_y_id", {27'd0, rsp_id, rsp_y}, {27'd0, 1'b0, model(2'b01, 2'd2, 2'd3)});
      chk("bp_readys", {30'd0, req1_ready, req0_ready}, 32'd0);
      chk("bp_cnt", {16'd0, grant_cnt0, grant_cnt1}, {16'd0, 8'd1, 8'd0});
      tick();
    end
    check_rsp("bp");
    req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    tick();
    chk("bp_release", {31'd0, rsp_valid}, 32'd0);

    // Reset during EXEC
    run_op(1'b0, 2'b00, 2'd2, 2'd0, "pre_rst");
    req0_valid = 1; req0_op = 2'b11; req0_a = 2'd2; req0_b = 2'd2;
    #1;
    wait_ready();
    sb.push_back('{id: 1'b0, y: model(2'b11, 2'd2, 2'd2)});
    tick();
    req0_valid = 0;
    rst_n = 0;
    #1;
    sb.delete();
    chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_cnt", {16'd0, grant_cnt0, grant_cnt1}, 32'd0);
    chk("mid_rst_y", {27'd0, rsp_id, rsp_y}, 32'd0);
    tick();
    rst_n = 1;
    tick();
    chk("post_rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    req0_valid = 1; req1_valid = 1;
    #1;
    chk("post_rst_tie", {30'd0, req1_ready, req0_ready}, 32'd1);
    req0_valid = 0; req1_valid = 0;
    tick();

    // Saturation on the CNT_W=2 instance
    for (int k = 1; k <= 6; k++) begin
      s_v = 1;
      #1;
      for (int i = 0; i < 20 && !s_rdy; i++) tick();
      chk("sat_ready", {31'd0, s_rdy}, 32'd1);
      tick();
      s_v = 0;
      tick();
      chk("sat_cnt", {30'd0, s_cnt0}, (k < 3) ? k : 3);
      chk("sat_y", {27'd0, s_rsp_valid, s_rsp_y}, {27'd0, 1'b1, model(2'b10, 2'd1, 2'd1)});
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
